// File: rtl/sample_source.sv
// Debounced pushbutton sampler. Btn is synchronised, debounced by a four-state
// FSM with a 20-bit stability counter, and each accepted press captures the
// slide switches into Din with a one-cycle Sample strobe and bumps Count.
module sample_source #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Switches,
  input  logic       Btn,
  output logic [7:0] Din,
  output logic       Sample,
  output logic       Pressed,
  output logic [7:0] Count
);

  localparam logic [1:0] StIdle        = 2'd0;
  localparam logic [1:0] StPressWait   = 2'd1;
  localparam logic [1:0] StHeld        = 2'd2;
  localparam logic [1:0] StReleaseWait = 2'd3;

  // Terminal count: the counter stops here and never wraps.
  localparam logic [19:0] CntMax = 20'(DEBOUNCE_CYCLES - 1);

  logic        btn_meta_q;
  logic        btn_s;
  logic [1:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        accept;
  logic [7:0]  din_q, din_d;
  logic        sample_q;
  logic        pressed_q, pressed_d;
  logic [7:0]  count_q, count_d;

  // Two-flop synchroniser; btn_s is the only view of Btn used elsewhere.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_meta_q <= 1'b0;
      btn_s      <= 1'b0;
    end else begin
      btn_meta_q <= Btn;
      btn_s      <= btn_meta_q;
    end
  end

  // Debounce FSM next state; accept marks the edge that takes a press.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!btn_s) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d = StHeld;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StHeld: begin
        if (!btn_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (btn_s) begin
          // Release bounce: back to held without a new strobe.
          state_d = StHeld;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values; Din and Count only move on an accepted press.
  always_comb begin
    din_d     = accept ? Switches : din_q;
    count_d   = accept ? count_q + 8'd1 : count_q;
    pressed_d = (state_d == StHeld) || (state_d == StReleaseWait);
  end

  // State, counter and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      din_q     <= 8'h00;
      sample_q  <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      sample_q  <= accept;
      pressed_q <= pressed_d;
      count_q   <= count_d;
    end
  end

  assign Din     = din_q;
  assign Sample  = sample_q;
  assign Pressed = pressed_q;
  assign Count   = count_q;

endmodule

// File: tb/tb_sample_source.sv
// Directed bench for sample_source with DEBOUNCE_CYCLES=4, plus a second
// instance at DEBOUNCE_CYCLES=1 for the minimum-debounce boundary.
module tb_sample_source;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Switches = 8'h00;
  logic       Btn = 1'b0;
  logic [7:0] Din;
  logic       Sample;
  logic       Pressed;
  logic [7:0] Count;

  logic       btn1 = 1'b0;
  logic [7:0] din1;
  logic       sample1;
  logic       pressed1;
  logic [7:0] count1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  sample_source #(.DEBOUNCE_CYCLES(4)) u_dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Switches (Switches),
    .Btn      (Btn),
    .Din      (Din),
    .Sample   (Sample),
    .Pressed  (Pressed),
    .Count    (Count)
  );

  sample_source #(.DEBOUNCE_CYCLES(1)) u_dut1 (
    .Clock    (Clock),
    .Reset    (Reset),
    .Switches (Switches),
    .Btn      (btn1),
    .Din      (din1),
    .Sample   (sample1),
    .Pressed  (pressed1),
    .Count    (count1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_din"}, 32'(Din), 32'h00);
    check({tag, "_sample"}, 32'(Sample), 32'h0);
    check({tag, "_pressed"}, 32'(Pressed), 32'h0);
    check({tag, "_count"}, 32'(Count), 32'h00);
  endtask

  // Press from idle: Sample exactly in cycle 7 after Btn rises.
  task automatic press(input string tag, input logic [7:0] sw, input logic [7:0] exp_cnt);
    Switches = sw;
    Btn = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      check({tag, "_sample"}, 32'(Sample), 32'(n == 7));
      if (n == 6) check({tag, "_pressed_pre"}, 32'(Pressed), 32'h0);
    end
    check({tag, "_din"}, 32'(Din), 32'(sw));
    check({tag, "_count"}, 32'(Count), 32'(exp_cnt));
    check({tag, "_pressed"}, 32'(Pressed), 32'h1);
  endtask

  // Release: Pressed drops on the 7th edge after Btn falls.
  task automatic release_btn(input string tag);
    Btn = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 6) check({tag, "_rel_pressed6"}, 32'(Pressed), 32'h1);
      if (n == 7) check({tag, "_rel_pressed7"}, 32'(Pressed), 32'h0);
    end
  endtask

  initial begin
    int samples;
    int doubles;
    int pmin;
    logic prev;

    // Reset state
    #2;
    check_zero("reset");
    tick();
    tick();
    check_zero("reset_clk");
    Reset = 1'b0;
    tick();
    check_zero("post_reset");

    // Basic press and release with A5
    press("basic", 8'hA5, 8'd1);
    release_btn("basic");

    // Short bounce rejected
    Switches = 8'h3C;
    Btn = 1'b1;
    samples = 0;
    for (int n = 1; n <= 15; n++) begin
      if (n == 4) Btn = 1'b0;
      tick();
      if (Sample) samples++;
    end
    check("bounce_samples", 32'(samples), 32'd0);
    check("bounce_din", 32'(Din), 32'hA5);
    check("bounce_count", 32'(Count), 32'd1);
    check("bounce_pressed", 32'(Pressed), 32'h0);

    // Back in idle: a fresh press has full latency
    press("glitch", 8'h5A, 8'd2);
    Btn = 1'b0;
    tick();
    tick();
    Btn = 1'b1;
    samples = 0;
    pmin = 1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (Sample) samples++;
      if (!Pressed) pmin = 0;
    end
    check("glitch_samples", 32'(samples), 32'd0);
    check("glitch_pressed", 32'(pmin), 32'd1);
    check("glitch_count", 32'(Count), 32'd2);
    release_btn("glitch");

    // Switches churning while held and releasing
    press("churn", 8'h11, 8'd3);
    for (int n = 0; n < 10; n++) begin
      Switches = ~Switches;
      tick();
    end
    Btn = 1'b0;
    for (int n = 0; n < 10; n++) begin
      Switches = Switches + 8'h37;
      tick();
    end
    check("churn_din", 32'(Din), 32'h11);
    check("churn_count", 32'(Count), 32'd3);
    check("churn_pressed", 32'(Pressed), 32'h0);

    // 256 presses from a cleared count
    Reset = 1'b1;
    #2;
    check_zero("reset2");
    tick();
    Reset = 1'b0;
    tick();
    samples = 0;
    doubles = 0;
    prev = 1'b0;
    for (int i = 0; i < 256; i++) begin
      Switches = 8'(i);
      Btn = 1'b1;
      for (int n = 0; n < 8; n++) begin
        tick();
        if (Sample) samples++;
        if (Sample && prev) doubles++;
        prev = Sample;
      end
      Btn = 1'b0;
      for (int n = 0; n < 8; n++) begin
        tick();
        if (Sample) samples++;
        if (Sample && prev) doubles++;
        prev = Sample;
      end
    end
    check("wrap_count", 32'(Count), 32'h00);
    check("wrap_din", 32'(Din), 32'hFF);
    check("wrap_samples", 32'(samples), 32'd256);
    check("wrap_doubles", 32'(doubles), 32'd0);

    // Reset mid-debounce with Btn held
    Switches = 8'h77;
    Btn = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    Reset = 1'b1;
    #1;
    check_zero("midreset");
    tick();
    tick();
    check_zero("midreset_clk");
    Reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check("postreset_sample", 32'(Sample), 32'(n == 7));
    end
    check("postreset_count", 32'(Count), 32'd1);
    check("postreset_din", 32'(Din), 32'h77);

    // Reset while Sample is high aborts the strobe
    Btn = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    Switches = 8'h42;
    Btn = 1'b1;
    for (int n = 0; n < 7; n++) tick();
    check("abort_sample_pre", 32'(Sample), 32'h1);
    Btn = 1'b0;
    Reset = 1'b1;
    #1;
    check("abort_sample", 32'(Sample), 32'h0);
    check("abort_count", 32'(Count), 32'h00);
    tick();
    Reset = 1'b0;
    samples = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (Sample) samples++;
    end
    check("abort_samples", 32'(samples), 32'd0);

    // DEBOUNCE_CYCLES=1: Sample in cycle 4
    Switches = 8'hC3;
    btn1 = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      check("d1_sample", 32'(sample1), 32'(n == 4));
    end
    check("d1_din", 32'(din1), 32'hC3);
    check("d1_count", 32'(count1), 32'd1);
    check("d1_pressed", 32'(pressed1), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
